mips_step_ctrl: RTL and testbench

Execution controller for the single-cycle MIPS core. Turns the raw `change` (run/halt toggle) and `step` push-button inputs into a clean, synchronised per-cycle `cpu_en` that gates every state update in the core: PC, register file and data-memory writes. Sits between the board/bench inputs and `mips`. Also keeps cycle and step counters for debug.

---
 rtl/mips_step_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mips_step_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_step_ctrl.sv
// -----------------------------------------------------------------------------
// mips_step_ctrl -- execution controller for the single-cycle MIPS core.
//
// Conditions the asynchronous run/halt toggle (change) and single-step (step)
// buttons (synchroniser, debouncer, rising-edge pulse) and runs a RUN/HALT/STEP
// state machine whose registered state gates every core state update through
// cpu_en. Also keeps debug counters of enabled cycles and STEP entries.
//
// Optional feature: define MIPS_STEP_BREAKPOINT_EN to add a PC breakpoint
// (ports pc, bp_addr, bp_valid, bp_hit).
//
// Ports:
//   clk        in   core clock, rising edge
//   rst        in   synchronous active-high reset
//   change     in   async run/halt toggle request (rising edge acts)
//   step       in   async single-step request (rising edge acts)
//   cpu_en     out  core advances one instruction in each cycle this is high
//   mode       out  current state: 0 = RUN, 1 = HALT, 2 = STEP
//   cycle_cnt  out  number of cycles with cpu_en = 1 (wraps)
//   step_cnt   out  number of STEP entries (wraps)
//   pc         in   core PC                        (MIPS_STEP_BREAKPOINT_EN)
//   bp_addr    in   breakpoint address             (MIPS_STEP_BREAKPOINT_EN)
//   bp_valid   in   breakpoint enable              (MIPS_STEP_BREAKPOINT_EN)
//   bp_hit     out  one-cycle pulse on a breakpoint halt (MIPS_STEP_BREAKPOINT_EN)
// -----------------------------------------------------------------------------

// Input conditioner: SYNC_STAGES flop synchroniser, debouncer, registered
// rising-edge pulse.
//   clk, rst  clock / synchronous reset
//   raw       asynchronous button level
//   pulse     one-cycle pulse per accepted rising edge of the debounced level
module mips_step_ctrl_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   level_d1_q;
  logic                   pulse_q;

  assign synced = sync_q[SYNC_STAGES-1];
  assign pulse  = pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      level_d1_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};

      // Counter tracks consecutive samples disagreeing with the held level;
      // the DEBOUNCE_CYCLES-th such sample flips the level.
      if (synced == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        level_q <= synced;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end

      level_d1_q <= level_q;
      // Registered so the FSM only ever sees a flop output.
      pulse_q    <= level_q & ~level_d1_q;
    end
  end

endmodule

module mips_step_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change,
  input  logic             step,
  output logic             cpu_en,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] step_cnt
`ifdef MIPS_STEP_BREAKPOINT_EN
  ,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
  output logic             bp_hit
`endif
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   run_ok_q;
  logic   chg_p, stp_p;
  logic   bp_match;

  mips_step_ctrl_cond #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_chg_cond (
    .clk   (clk),
    .rst   (rst),
    .raw   (change),
    .pulse (chg_p)
  );

  mips_step_ctrl_cond #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_stp_cond (
    .clk   (clk),
    .rst   (rst),
    .raw   (step),
    .pulse (stp_p)
  );

`ifdef MIPS_STEP_BREAKPOINT_EN
  logic prev_run_q;
  logic bp_hit_q;

  // prev_run_q low marks the first RUN cycle after HALT/STEP, where matching
  // is masked so a resume at the breakpoint address does not re-trigger.
  assign bp_match = (state_q == RUN) && prev_run_q && bp_valid && (pc == bp_addr);
  assign bp_hit   = bp_hit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_run_q <= 1'b1;
      bp_hit_q   <= 1'b0;
    end else begin
      prev_run_q <= (state_q == RUN);
      bp_hit_q   <= bp_match;
    end
  end
`else
  assign bp_match = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (chg_p || bp_match) state_d = HALT;
      HALT: begin
        if (chg_p)      state_d = RUN;   // change beats a simultaneous step
        else if (stp_p) state_d = STEP;
      end
      STEP:    state_d = chg_p ? RUN : HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      run_ok_q  <= 1'b0;
      cycle_cnt <= '0;
      step_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      run_ok_q <= 1'b1;
      if (cpu_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if ((state_d == STEP) && (state_q != STEP)) step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  // run_ok_q holds the core off during reset while state_q already reads RUN;
  // both terms are flops, so cpu_en has no combinational input path.
  assign cpu_en = run_ok_q && ((state_q == RUN) || (state_q == STEP));
  assign mode   = state_q;

endmodule

// File: tb/tb_mips_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_step_ctrl -- self-checking bench for mips_step_ctrl (default
// parameters). Each test pushes the expected per-cycle {mode, cpu_en,
// cycle_cnt, step_cnt} onto a scoreboard queue, then drives the button
// pattern and compares the DUT at every falling edge against the popped entry.
// -----------------------------------------------------------------------------
module tb_mips_step_ctrl;

  localparam logic [1:0] M_RUN  = 2'd0;
  localparam logic [1:0] M_HALT = 2'd1;
  localparam logic [1:0] M_STEP = 2'd2;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        change = 1'b0;
  logic        step   = 1'b0;
  logic        cpu_en;
  logic [1:0]  mode;
  logic [31:0] cycle_cnt;
  logic [31:0] step_cnt;
`ifdef MIPS_STEP_BREAKPOINT_EN
  logic [31:0] pc;
  logic [31:0] bp_addr  = 32'h0000_0010;
  logic        bp_valid = 1'b0;
  logic        bp_hit;
`endif

  typedef struct packed {
    logic [1:0]  mode;
    logic        en;
    logic [31:0] cc;
    logic [31:0] sc;
  } exp_t;

  exp_t        sb[$];
  int unsigned exp_cc = 0;
  int unsigned exp_sc = 0;
  int          total  = 0;
  int          bad    = 0;

  always #5 clk = ~clk;

  mips_step_ctrl #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .change    (change),
    .step      (step),
    .cpu_en    (cpu_en),
    .mode      (mode),
    .cycle_cnt (cycle_cnt),
    .step_cnt  (step_cnt)
`ifdef MIPS_STEP_BREAKPOINT_EN
    ,
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_valid  (bp_valid),
    .bp_hit    (bp_hit)
`endif
  );

`ifdef MIPS_STEP_BREAKPOINT_EN
  // Minimal core stand-in: PC advances by 4 on every enabled cycle.
  always @(posedge clk) begin
    if (rst)         pc <= 32'h0;
    else if (cpu_en) pc <= pc + 32'd4;
  end
`endif

  // Expected state seen at the falling edge; step_cnt already counts a STEP
  // being entered, cycle_cnt counts only earlier enabled cycles.
  task automatic push(input logic [1:0] m, input logic en);
    exp_t e;
    if (m == M_STEP) exp_sc++;
    e.mode = m;
    e.en   = en;
    e.cc   = exp_cc;
    e.sc   = exp_sc;
    sb.push_back(e);
    if (en) exp_cc++;
  endtask

  task automatic push_n(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) push(m, m != M_HALT);
  endtask

  function automatic string fmt(input exp_t v);
    return $sformatf("mode=%0d en=%0b cyc=%0d stp=%0d", v.mode, v.en, v.cc, v.sc);
  endfunction

  task automatic test_reset();
    exp_t e, obs;
    for (int i = 0; i < 3; i++) push(M_RUN, 1'b0);
    push_n(4, M_RUN);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      obs = {mode, cpu_en, cycle_cnt, step_cnt};
      e   = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset[%0d]: got %s want %s", i, fmt(obs), fmt(e));
      end
      if (i == 2) rst = 1'b0;
    end
  endtask

  task automatic test_halt_latency();
    exp_t e, obs;
    push_n(8, M_RUN);
    push_n(14, M_HALT);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      obs = {mode, cpu_en, cycle_cnt, step_cnt};
      e   = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL halt_latency[%0d]: got %s want %s", i, fmt(obs), fmt(e));
      end
      change = (i < 12);
      step   = 1'b0;
    end
  endtask

  task automatic test_single_step();
    exp_t e, obs;
    for (int p = 0; p < 2; p++) begin
      push_n(8, M_HALT);
      push_n(1, M_STEP);
      push_n(11, M_HALT);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      obs = {mode, cpu_en, cycle_cnt, step_cnt};
      e   = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL single_step[%0d]: got %s want %s", i, fmt(obs), fmt(e));
      end
      change = 1'b0;
      step   = ((i % 20) < 10);
    end
  endtask

  task automatic test_bounce();
    exp_t e, obs;
    push_n(22, M_HALT);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      obs = {mode, cpu_en, cycle_cnt, step_cnt};
      e   = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL bounce[%0d]: got %s want %s", i, fmt(obs), fmt(e));
      end
      change = 1'b0;
      step   = (i < 12) && ((i % 3) != 2);
    end
  endtask

  // A: change+step together in HALT -> RUN, step dropped.
  // B: change -> HALT again.
  // C: step, then change one cycle later so its pulse lands in the STEP cycle.
  task automatic test_simultaneous();
    exp_t e, obs;
    push_n(8, M_HALT);  push_n(12, M_RUN);
    push_n(8, M_RUN);   push_n(12, M_HALT);
    push_n(8, M_HALT);  push_n(1, M_STEP);  push_n(11, M_RUN);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      obs = {mode, cpu_en, cycle_cnt, step_cnt};
      e   = sb.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL simultaneous[%0d]: got %s want %s", i, fmt(obs), fmt(e));
      end
      change = (i < 10) || (i >= 20 && i < 30) || (i >= 41 && i < 50);
      step   = (i < 10) || (i >= 40 && i < 50);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
  endtask

`ifdef MIPS_STEP_BREAKPOINT_EN
  task automatic test_breakpoint();
    int waited;
    change   = 1'b0;
    step     = 1'b0;
    rst      = 1'b1;
    bp_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (mode !== M_HALT && waited < 30);
    total++;
    if (mode !== M_HALT) begin
      bad++;
      $display("FAIL bp_halt: got mode=%0d want %0d", mode, M_HALT);
    end
    total++;
    if (bp_hit !== 1'b1) begin
      bad++;
      $display("FAIL bp_hit_pulse: got %0b want 1", bp_hit);
    end
    total++;
    if (pc !== 32'h14) begin
      bad++;
      $display("FAIL bp_pc: got %h want 00000014", pc);
    end
    @(negedge clk);
    total++;
    if (bp_hit !== 1'b0 || mode !== M_HALT) begin
      bad++;
      $display("FAIL bp_hit_single: got hit=%0b mode=%0d want hit=0 mode=1", bp_hit, mode);
    end
    change = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
      if (waited == 10) change = 1'b0;
    end while (mode !== M_RUN && waited < 30);
    change = 1'b0;
    total++;
    if (mode !== M_RUN) begin
      bad++;
      $display("FAIL bp_resume: got mode=%0d want %0d", mode, M_RUN);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (mode !== M_RUN || bp_hit !== 1'b0) begin
        bad++;
        $display("FAIL bp_no_rehit[%0d]: got mode=%0d hit=%0b want mode=0 hit=0", i, mode, bp_hit);
      end
    end
    bp_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_halt_latency();
    test_single_step();
    test_bounce();
    test_simultaneous();
`ifdef MIPS_STEP_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
